// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU, iterative 32-cycle shift-add multiplier
// feeding HI/LO, and the EX/MEM pipeline register for the memory stage.
module exec_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [4:0]  shamt,
    input  logic [4:0]  in_wsel,
    input  logic [1:0]  in_wdat_source,
    input  logic        in_dmemREN,
    input  logic        in_dmemWEN,
    input  logic [31:0] in_dmemstore,
    input  logic        in_halt,
    input  logic [31:0] in_instr_npc,
    output logic        exec_stall,
    output logic [31:0] out_alu_result,
    output logic [4:0]  out_wsel,
    output logic [1:0]  out_wdat_source,
    output logic        out_dmemREN,
    output logic        out_dmemWEN,
    output logic [31:0] out_dmemstore,
    output logic        out_halt,
    output logic [31:0] out_instr_npc
);
    // state | meaning
    // IDLE  | no multiply in flight; a MULT/MULTU in EX starts one
    // BUSY  | one shift-add iteration per cycle
    // DONE  | HI/LO hold the product; waiting for the pipeline to advance
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_MULTU = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

    mul_state_t        state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [63:0]       mcand;
    logic [31:0]       mplier;
    logic [63:0]       acc;
    logic [63:0]       acc_nxt;
    logic              neg;
    logic [31:0]       hi, lo;
    logic [31:0]       alu_result;
    logic              is_mul;
    logic              mul_start;
    logic              mul_last;
    logic [31:0]       mag_a, mag_b;

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign mul_start = is_mul && !flush;
    assign mul_last  = (count == CNT_W'(MUL_CYCLES - 1));

    // Signed multiply runs on magnitudes; the sign is applied once at the end.
    assign mag_a   = (op == OP_MULT && opa[31]) ? (32'd0 - opa) : opa;
    assign mag_b   = (op == OP_MULT && opb[31]) ? (32'd0 - opb) : opb;
    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        alu_result = 32'd0;
        case (op)
            OP_ADD:  alu_result = opa + opb;
            OP_SUB:  alu_result = opa - opb;
            OP_AND:  alu_result = opa & opb;
            OP_OR:   alu_result = opa | opb;
            OP_XOR:  alu_result = opa ^ opb;
            OP_NOR:  alu_result = ~(opa | opb);
            OP_SLT:  alu_result = {31'd0, $signed(opa) < $signed(opb)};
            OP_SLTU: alu_result = {31'd0, opa < opb};
            OP_SLL:  alu_result = opb << shamt;
            OP_SRL:  alu_result = opb >> shamt;
            OP_SRA:  alu_result = 32'($signed(opb) >>> shamt);
            OP_LUI:  alu_result = {opb[15:0], 16'h0000};
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        exec_stall = is_mul && (state != DONE) && !flush;
        case (state)
            IDLE: if (mul_start) state_nxt = BUSY;
            BUSY: begin
                if (flush)         state_nxt = IDLE;
                else if (mul_last) state_nxt = DONE;
            end
            DONE: if (en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            neg    <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        count  <= '0;
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        acc    <= 64'd0;
                        neg    <= (op == OP_MULT) && (opa[31] ^ opb[31]);
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        if (mul_last)
                            {hi, lo} <= neg ? (64'd0 - acc_nxt) : acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // A stalled multiply feeds bubbles forward so MEM/WB drain behind it.
    always_ff @(posedge CLK) begin
        if (RST || (en && (flush || exec_stall))) begin
            out_alu_result  <= 32'd0;
            out_wsel        <= 5'd0;
            out_wdat_source <= 2'd0;
            out_dmemREN     <= 1'b0;
            out_dmemWEN     <= 1'b0;
            out_dmemstore   <= 32'd0;
            out_halt        <= 1'b0;
            out_instr_npc   <= 32'd0;
        end else if (en) begin
            out_alu_result  <= alu_result;
            out_wsel        <= in_wsel;
            out_wdat_source <= in_wdat_source;
            out_dmemREN     <= in_dmemREN;
            out_dmemWEN     <= in_dmemWEN;
            out_dmemstore   <= in_dmemstore;
            out_halt        <= in_halt;
            out_instr_npc   <= in_instr_npc;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: stimulus queues expected values tagged with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_exec_stage;
    logic        CLK, RST, en, flush;
    logic [3:0]  op;
    logic [31:0] opa, opb;
    logic [4:0]  shamt, in_wsel;
    logic [1:0]  in_wdat_source;
    logic        in_dmemREN, in_dmemWEN, in_halt;
    logic [31:0] in_dmemstore, in_instr_npc;
    logic        exec_stall;
    logic [31:0] out_alu_result, out_dmemstore, out_instr_npc;
    logic [4:0]  out_wsel;
    logic [1:0]  out_wdat_source;
    logic        out_dmemREN, out_dmemWEN, out_halt;

    exec_stage #(.MUL_CYCLES(32)) dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .op(op),
        .opa(opa), .opb(opb), .shamt(shamt), .in_wsel(in_wsel),
        .in_wdat_source(in_wdat_source), .in_dmemREN(in_dmemREN),
        .in_dmemWEN(in_dmemWEN), .in_dmemstore(in_dmemstore),
        .in_halt(in_halt), .in_instr_npc(in_instr_npc),
        .exec_stall(exec_stall), .out_alu_result(out_alu_result),
        .out_wsel(out_wsel), .out_wdat_source(out_wdat_source),
        .out_dmemREN(out_dmemREN), .out_dmemWEN(out_dmemWEN),
        .out_dmemstore(out_dmemstore), .out_halt(out_halt),
        .out_instr_npc(out_instr_npc)
    );

    localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, NOR_ = 5,
                           SLT = 6, SLTU = 7, SLL = 8, SRL = 9, SRA = 10, LUI = 11,
                           MULT = 12, MULTU = 13, MFHI = 14, MFLO = 15;
    localparam int K_STALL = 0, K_ALU = 1, K_WSEL = 2, K_WEN = 3, K_NPC = 4, K_BUBBLE = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            K_STALL: return {31'd0, exec_stall};
            K_ALU:   return out_alu_result;
            K_WSEL:  return {27'd0, out_wsel};
            K_WEN:   return {31'd0, out_dmemWEN};
            K_NPC:   return out_instr_npc;
            K_BUBBLE: return out_alu_result | out_dmemstore | out_instr_npc |
                             {22'd0, out_wsel, out_wdat_source, out_dmemREN, out_dmemWEN, out_halt};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial forever begin
        exp_t        e;
        logic [31:0] act;
        @(negedge CLK);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.kind);
            total = total + 1;
            if (act === e.exp) passed = passed + 1;
            else $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.exp);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_at(input int off, input int kind, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + off;
        e.kind = kind;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic set_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        op = o; opa = a; opb = b; shamt = sh;
    endtask

    task automatic alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] r, input string n);
        set_op(o, a, b, sh);
        en = 1'b1; flush = 1'b0;
        expect_at(0, K_STALL, 32'd0, {n, "_stall"});
        expect_at(1, K_ALU, r, n);
        tick();
    endtask

    task automatic run_mult(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input string n);
        set_op(o, a, b, 5'd0);
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 34; i++) begin
            expect_at(0, K_STALL, (i < 33) ? 32'd1 : 32'd0, {n, "_stall"});
            if (i < 33) expect_at(1, K_BUBBLE, 32'd0, {n, "_bubble"});
            tick();
        end
    endtask

    task automatic check_hilo(input logic [31:0] h, input logic [31:0] l, input string n);
        alu(MFHI, 32'd0, 32'd0, 5'd0, h, {n, "_hi"});
        alu(MFLO, 32'd0, 32'd0, 5'd0, l, {n, "_lo"});
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; flush = 1'b0;
        set_op(ADD, 32'd0, 32'd0, 5'd0);
        in_wsel = 5'd0; in_wdat_source = 2'd0; in_dmemREN = 1'b0; in_dmemWEN = 1'b0;
        in_dmemstore = 32'd0; in_halt = 1'b0; in_instr_npc = 32'd0;
        tick();
        expect_at(0, K_BUBBLE, 32'd0, "reset_outs");
        expect_at(0, K_STALL, 32'd0, "reset_stall");
        tick();
        RST = 1'b0;

        alu(ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, "add_wrap");
        alu(SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, "slt");
        alu(SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, "sltu");
        alu(SRA,  32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, "sra");
        alu(LUI,  32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, "lui");
        alu(SUB,  32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, "sub");
        alu(NOR_, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'hF0F0_FF0F, "nor");
        alu(XOR_, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'hF0F0_F0F0, "xor");
        alu(SLL,  32'h0, 32'h1, 5'd31, 32'h8000_0000, "sll");
        alu(SRL,  32'h0, 32'h8000_0000, 5'd31, 32'h1, "srl");

        // en low: outputs keep the SRL result even though a new ADD is presented
        set_op(ADD, 32'd2, 32'd3, 5'd0);
        in_wsel = 5'd3; in_dmemWEN = 1'b1; in_instr_npc = 32'h104; en = 1'b0;
        expect_at(1, K_ALU, 32'h1, "hold_alu");
        expect_at(1, K_WSEL, 32'd0, "hold_wsel");
        tick();
        expect_at(1, K_ALU, 32'h1, "hold_alu2");
        tick();
        en = 1'b1;
        expect_at(1, K_ALU, 32'd5, "en_alu");
        expect_at(1, K_WSEL, 32'd3, "en_wsel");
        expect_at(1, K_WEN, 32'd1, "en_wen");
        expect_at(1, K_NPC, 32'h104, "en_npc");
        tick();
        in_wsel = 5'd0; in_dmemWEN = 1'b0; in_instr_npc = 32'd0;

        run_mult(MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1x2");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_m1x2");
        run_mult(MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        check_hilo(32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_mult(MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
        check_hilo(32'h4000_0000, 32'h0000_0000, "mult_min");

        // 0xFFFF * 0xAAAAAAAB = 0x0000AAAA_00005555
        run_mult(MULTU, 32'h0000_FFFF, 32'hAAAA_AAAB, "preload");
        check_hilo(32'h0000_AAAA, 32'h0000_5555, "preload");

        set_op(MULT, 32'd3, 32'd4, 5'd0);
        in_wsel = 5'd7; in_instr_npc = 32'h200;
        for (int i = 0; i < 10; i++) begin
            expect_at(0, K_STALL, 32'd1, "flushmul_stall");
            tick();
        end
        flush = 1'b1;
        expect_at(0, K_STALL, 32'd0, "flush_stall");
        expect_at(1, K_BUBBLE, 32'd0, "flush_bubble");
        tick();
        flush = 1'b0; in_wsel = 5'd0; in_instr_npc = 32'd0;
        check_hilo(32'h0000_AAAA, 32'h0000_5555, "flush_keep");

        // Reset mid-multiply with en low so the outputs are non-zero beforehand
        set_op(MULT, 32'd7, 32'd9, 5'd0);
        en = 1'b0;
        expect_at(1, K_ALU, 32'h0000_5555, "hold_in_mult");
        for (int i = 0; i < 5; i++) begin
            expect_at(0, K_STALL, 32'd1, "rstmul_stall");
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        set_op(MFHI, 32'd0, 32'd0, 5'd0);
        en = 1'b1;
        expect_at(0, K_STALL, 32'd0, "rst_stall");
        expect_at(0, K_BUBBLE, 32'd0, "rst_outs");
        expect_at(1, K_ALU, 32'd0, "rst_hi");
        tick();
        alu(MFLO, 32'd0, 32'd0, 5'd0, 32'd0, "rst_lo");

        run_mult(MULTU, 32'd3, 32'd5, "b2b_first");
        run_mult(MULT, 32'hFFFF_FFFD, 32'd5, "b2b_second");
        check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFF1, "b2b");

        set_op(ADD, 32'd0, 32'd0, 5'd0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            total = total + 1;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
